// File: rtl/alu_exec_unit.sv
// EX-stage ALU: decodes alu_op/funct3/funct7 to an op code, executes it and holds a registered result
// behind a valid/ready handshake. Define ALU_EXEC_MUL_EN to add the multi-cycle shift-add multiplier.
module alu_exec_unit #(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic            i_30,
  input  logic            i_25,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [3:0]      alu_ctl,
  output logic            illegal,
  output logic            busy
);
  localparam int SHW = $clog2(XLEN);

  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_SLL  = 4'b0011;
  localparam logic [3:0] C_XOR  = 4'b0100;
  localparam logic [3:0] C_SRL  = 4'b0101;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_SLT  = 4'b0111;
  localparam logic [3:0] C_SLTU = 4'b1000;
  localparam logic [3:0] C_SRA  = 4'b1001;
  localparam logic [3:0] C_MUL  = 4'b1010;

  logic [3:0]      w_ctl;
  logic            w_illegal;
  logic            w_is_mul;
  logic [XLEN-1:0] w_res;
  logic [SHW-1:0]  w_shamt;
  logic            w_idle;
  logic            w_accept;
  logic            w_mul_done;
  logic [XLEN-1:0] w_acc_next;

  logic            r_valid;
  logic [XLEN-1:0] r_result;
  logic            r_zero;
  logic [3:0]      r_ctl;
  logic            r_illegal;

  // ---------------- decode ----------------
  always_comb begin
    w_ctl     = C_ADD;
    w_illegal = 1'b0;
    w_is_mul  = 1'b0;
    case (alu_op)
      2'b00: w_ctl = C_ADD;
      2'b01: w_ctl = C_SUB;
      default: begin
        if (alu_op == 2'b10 && i_25) begin
`ifdef ALU_EXEC_MUL_EN
          if (funct3 == 3'b000) begin
            w_ctl    = C_MUL;
            w_is_mul = 1'b1;
          end else begin
            w_ctl     = C_AND;
            w_illegal = 1'b1;
          end
`else
          w_ctl     = C_AND;
          w_illegal = 1'b1;
`endif
        end else begin
          case (funct3)
            3'b000:  w_ctl = (alu_op == 2'b10 && i_30) ? C_SUB : C_ADD;
            3'b001:  w_ctl = C_SLL;
            3'b010:  w_ctl = C_SLT;
            3'b011:  w_ctl = C_SLTU;
            3'b100:  w_ctl = C_XOR;
            3'b101:  w_ctl = i_30 ? C_SRA : C_SRL;
            3'b110:  w_ctl = C_OR;
            default: w_ctl = C_AND;
          endcase
        end
      end
    endcase
  end

  // ---------------- single-cycle execute ----------------
  assign w_shamt = op_b[SHW-1:0];

  always_comb begin
    w_res = '0;
    case (w_ctl)
      C_AND:   w_res = op_a & op_b;
      C_OR:    w_res = op_a | op_b;
      C_ADD:   w_res = op_a + op_b;
      C_SLL:   w_res = op_a << w_shamt;
      C_XOR:   w_res = op_a ^ op_b;
      C_SRL:   w_res = op_a >> w_shamt;
      C_SUB:   w_res = op_a - op_b;
      C_SLT:   w_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      C_SLTU:  w_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      C_SRA:   w_res = $unsigned($signed(op_a) >>> w_shamt);
      default: w_res = '0;
    endcase
    // illegal shares code 0000 with AND, so force the zero result here
    if (w_illegal) w_res = '0;
  end

  assign in_ready = rst_n && w_idle && (!r_valid || out_ready);
  assign w_accept = in_valid && in_ready;

`ifdef ALU_EXEC_MUL_EN
  // ---------------- shift-add multiplier ----------------
  localparam int STEPS = XLEN / MUL_BITS;
  localparam int CW    = $clog2(STEPS + 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;
  state_t r_state, w_state_nxt;

  logic [XLEN-1:0] r_mcand, r_mplier, r_acc, w_partial;
  logic [CW-1:0]   r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_is_mul) w_state_nxt = S_BUSY;
      default: if (w_mul_done) w_state_nxt = S_IDLE;
    endcase
  end

  assign w_idle     = (r_state == S_IDLE);
  assign busy       = (r_state == S_BUSY);
  assign w_mul_done = (r_state == S_BUSY) && (r_cnt == CW'(STEPS - 1));

  always_comb begin
    w_partial = '0;
    for (int j = 0; j < MUL_BITS; j++)
      if (r_mplier[j]) w_partial = w_partial + (r_mcand << j);
    w_acc_next = r_acc + w_partial;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_idle && w_accept && w_is_mul) begin
      r_mcand  <= op_a;
      r_mplier <= op_b;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (!w_idle) begin
      r_mcand  <= r_mcand << MUL_BITS;
      r_mplier <= r_mplier >> MUL_BITS;
      r_acc    <= w_acc_next;
      r_cnt    <= r_cnt + 1'b1;
    end
  end
`else
  assign w_idle     = 1'b1;
  assign w_mul_done = 1'b0;
  assign w_acc_next = '0;
  // no multiplier: constant 0 for every legal MUL_BITS
  assign busy       = (MUL_BITS < 1);
`endif

  // ---------------- output register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_ctl     <= 4'b0000;
      r_illegal <= 1'b0;
    end else if (w_accept && !w_is_mul) begin
      r_valid   <= 1'b1;
      r_result  <= w_res;
      r_zero    <= (w_res == '0);
      r_ctl     <= w_illegal ? 4'b0000 : w_ctl;
      r_illegal <= w_illegal;
    end else if (w_mul_done) begin
      r_valid   <= 1'b1;
      r_result  <= w_acc_next;
      r_zero    <= (w_acc_next == '0);
      r_ctl     <= C_MUL;
      r_illegal <= 1'b0;
    end else if (out_ready) begin
      r_valid   <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign alu_ctl   = r_ctl;
  assign illegal   = r_illegal;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: decode/execute vectors, stall/backpressure, reset, illegal ops,
// and the multiplier when ALU_EXEC_MUL_EN is defined.
module tb_alu_exec_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [1:0]  alu_op;
  logic        i_30, i_25;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        out_valid, out_ready;
  logic [31:0] result;
  logic        zero;
  logic [3:0]  alu_ctl;
  logic        illegal, busy;

  int total = 0;
  int bad   = 0;

  alu_exec_unit #(.XLEN(32), .MUL_BITS(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .i_30(i_30), .i_25(i_25), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .alu_ctl(alu_ctl), .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic        b30;
    logic [2:0]  f3;
    logic [31:0] a, b, exp;
    logic [3:0]  ctl;
  } vec_t;

  task automatic apply(input logic [1:0] op, input logic b30, input logic b25,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    alu_op = op; i_30 = b30; i_25 = b25; funct3 = f3; op_a = a; op_b = b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    apply(2'b00, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", result); end
    total++; if (zero !== 1'b0 || alu_ctl !== 4'h0 || illegal !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_flags got zero=%b ctl=%h ill=%b busy=%b exp all 0", zero, alu_ctl, illegal, busy);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_sub();
    @(posedge clk); #1;
    apply(2'b10, 1'b1, 1'b0, 3'b000, 32'd5, 32'd7);
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || result !== 32'hFFFF_FFFE) begin
      bad++; $display("FAIL sub_result got v=%b r=%h exp v=1 r=fffffffe", out_valid, result);
    end
    total++; if (alu_ctl !== 4'b0110 || zero !== 1'b0) begin
      bad++; $display("FAIL sub_ctl got ctl=%h zero=%b exp ctl=6 zero=0", alu_ctl, zero);
    end
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sub_drop got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    vec_t v[13];
    v[0]  = '{2'b11, 1'b1, 3'b000, 32'd3,         32'd3,      32'd6,          4'h2};
    v[1]  = '{2'b10, 1'b1, 3'b101, 32'h8000_0000, 32'd4,      32'hF800_0000,  4'h9};
    v[2]  = '{2'b10, 1'b0, 3'b010, 32'hFFFF_FFFF, 32'd1,      32'd1,          4'h7};
    v[3]  = '{2'b10, 1'b0, 3'b011, 32'hFFFF_FFFF, 32'd1,      32'd0,          4'h8};
    v[4]  = '{2'b10, 1'b0, 3'b101, 32'h8000_0000, 32'd4,      32'h0800_0000,  4'h5};
    v[5]  = '{2'b11, 1'b0, 3'b001, 32'd1,         32'd33,     32'd2,          4'h3};
    v[6]  = '{2'b10, 1'b0, 3'b100, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 4'h4};
    v[7]  = '{2'b10, 1'b0, 3'b110, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 4'h1};
    v[8]  = '{2'b10, 1'b0, 3'b111, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 4'h0};
    v[9]  = '{2'b00, 1'b1, 3'b101, 32'h10,        32'h20,     32'h30,         4'h2};
    v[10] = '{2'b01, 1'b0, 3'b000, 32'd7,         32'd7,      32'd0,          4'h6};
    v[11] = '{2'b11, 1'b1, 3'b101, 32'h8000_0000, 32'd4,      32'hF800_0000,  4'h9};
    v[12] = '{2'b10, 1'b0, 3'b000, 32'hFFFF_FFFF, 32'd1,      32'd0,          4'h2};
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      apply(v[i].op, v[i].b30, 1'b0, v[i].f3, v[i].a, v[i].b);
      in_valid = 1'b1;
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1 || result !== v[i].exp || alu_ctl !== v[i].ctl ||
                   zero !== (v[i].exp == 32'h0) || illegal !== 1'b0) begin
        bad++; $display("FAIL vec%0d got v=%b r=%h ctl=%h z=%b ill=%b exp r=%h ctl=%h", i,
                        out_valid, result, alu_ctl, zero, illegal, v[i].exp, v[i].ctl);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    out_ready = 1'b1;
    apply(2'b00, 1'b0, 1'b0, 3'b000, 32'd1, 32'd100);
    in_valid = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    apply(2'b00, 1'b0, 1'b0, 3'b000, 32'd2, 32'd100);
    #1;
    total++; if (out_valid !== 1'b1 || result !== 32'd101 || in_ready !== 1'b0) begin
      bad++; $display("FAIL stall_first got v=%b r=%0d rdy=%b exp v=1 r=101 rdy=0", out_valid, result, in_ready);
    end
    repeat (3) begin
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1 || result !== 32'd101 || in_ready !== 1'b0) begin
        bad++; $display("FAIL stall_hold got v=%b r=%0d rdy=%b exp v=1 r=101 rdy=0", out_valid, result, in_ready);
      end
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_release got=%b exp=1", in_ready); end
    for (int k = 2; k <= 8; k++) begin
      apply(2'b00, 1'b0, 1'b0, 3'b000, k, 32'd100);
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1 || result !== 32'(100 + k)) begin
        bad++; $display("FAIL stream%0d got v=%b r=%0d exp v=1 r=%0d", k, out_valid, result, 100 + k);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_end got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    apply(2'b00, 1'b0, 1'b0, 3'b000, 32'd9, 32'd9);
    in_valid = 1'b1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1 || result !== 32'd18) begin
      bad++; $display("FAIL pre_reset got v=%b r=%0d exp v=1 r=18", out_valid, result);
    end
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || result !== 32'h0 || zero !== 1'b0 || alu_ctl !== 4'h0 ||
                 illegal !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL midreset got v=%b r=%h z=%b ctl=%h ill=%b busy=%b exp all 0",
                      out_valid, result, zero, alu_ctl, illegal, busy);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL post_reset got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid);
    end
  endtask

  task automatic test_illegal();
    @(posedge clk); #1;
    out_ready = 1'b1;
    apply(2'b10, 1'b0, 1'b1, 3'b100, 32'd5, 32'd6);
    in_valid = 1'b1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1 || illegal !== 1'b1 || result !== 32'h0 || zero !== 1'b1 || alu_ctl !== 4'h0) begin
      bad++; $display("FAIL illegal_f3_100 got v=%b ill=%b r=%h z=%b ctl=%h exp v=1 ill=1 r=0 z=1 ctl=0",
                      out_valid, illegal, result, zero, alu_ctl);
    end
`ifndef ALU_EXEC_MUL_EN
    apply(2'b10, 1'b0, 1'b1, 3'b000, 32'd5, 32'd6);
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b1 || illegal !== 1'b1 || result !== 32'h0 || zero !== 1'b1 || alu_ctl !== 4'h0) begin
      bad++; $display("FAIL illegal_mul_off got v=%b ill=%b r=%h z=%b ctl=%h exp v=1 ill=1 r=0 z=1 ctl=0",
                      out_valid, illegal, result, zero, alu_ctl);
    end
`endif
    apply(2'b10, 1'b0, 1'b0, 3'b000, 32'd1, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++; if (illegal !== 1'b0 || result !== 32'd2) begin
      bad++; $display("FAIL illegal_clear got ill=%b r=%0d exp ill=0 r=2", illegal, result);
    end
    @(posedge clk); #1;
  endtask

`ifdef ALU_EXEC_MUL_EN
  task automatic test_mul();
    int edges;
    int stall_bad;
    logic seen;
    out_ready = 1'b1;
    apply(2'b10, 1'b0, 1'b1, 3'b000, 32'hFFFF_FFFF, 32'd3);
    in_valid = 1'b1;
    @(posedge clk); #1;
    edges = 1; stall_bad = 0;
    apply(2'b00, 1'b0, 1'b0, 3'b000, 32'd1, 32'd1);
    while (!out_valid && edges < 100) begin
      if (busy !== 1'b1 || in_ready !== 1'b0) stall_bad++;
      @(posedge clk); #1;
      edges++;
    end
    in_valid = 1'b0;
    total++; if (stall_bad != 0) begin bad++; $display("FAIL mul_busy got %0d bad cycles exp 0", stall_bad); end
    total++; if (edges != 33) begin bad++; $display("FAIL mul_latency got=%0d exp=33", edges); end
    total++; if (result !== 32'hFFFF_FFFD || alu_ctl !== 4'hA || illegal !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL mul_result got r=%h ctl=%h ill=%b busy=%b exp r=fffffffd ctl=a ill=0 busy=0",
                      result, alu_ctl, illegal, busy);
    end
    @(posedge clk); #1;
    apply(2'b10, 1'b0, 1'b1, 3'b000, 32'd5, 32'd6);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL mul_abort got busy=%b v=%b exp 0 0", busy, out_valid);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL mul_aborted_result got activity=%b exp 0", seen); end
    apply(2'b10, 1'b0, 1'b1, 3'b000, 32'd5, 32'd6);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 1;
    while (!out_valid && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    total++; if (edges != 33 || result !== 32'd30 || zero !== 1'b0) begin
      bad++; $display("FAIL mul_small got edges=%0d r=%0d z=%b exp 33 30 0", edges, result, zero);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_sub();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_illegal();
`ifdef ALU_EXEC_MUL_EN
    test_mul();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
